// File: rtl/gray_rr_arbiter.sv
// Round-robin burst arbiter: one requester at a time owns the output mux for a
// burst that ends on req_last or after MAX_BEATS beats; the grant index is also exported Gray-coded.
module gray_rr_arbiter #(
    parameter int NR_REQ     = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NR_REQ-1:0]            req_valid,
    input  logic [NR_REQ-1:0]            req_last,
    input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NR_REQ-1:0]            req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [IDX_WIDTH-1:0]         out_sel_gray
);

    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] grant;
    logic [IDX_WIDTH-1:0] ptr;
    logic [CNT_W-1:0]     beat_cnt;

    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 any_valid;
    logic                 transfer;

    // Walks offsets from farthest to nearest so the nearest set index at or
    // above ptr (with wrap) is the last one written and wins.
    function automatic logic [IDX_WIDTH-1:0] rr_pick(
        input logic [NR_REQ-1:0]    v,
        input logic [IDX_WIDTH-1:0] p
    );
        logic [IDX_WIDTH-1:0] r;
        int unsigned          idx;
        r = '0;
        for (int unsigned i = NR_REQ; i > 0; i--) begin
            idx = (int'(p) + i - 1) % NR_REQ;
            if (v[idx]) begin
                r = IDX_WIDTH'(idx);
            end
        end
        return r;
    endfunction

    always_comb begin
        any_valid = |req_valid;
        pick_idx  = rr_pick(req_valid, ptr);
    end

    always_comb begin
        req_ready    = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        out_sel_gray = '0;
        if (state == BUSY) begin
            for (int unsigned i = 0; i < NR_REQ; i++) begin
                if (grant == IDX_WIDTH'(i)) begin
                    out_valid    = req_valid[i];
                    out_data     = req_data[DATA_WIDTH*i +: DATA_WIDTH];
                    req_ready[i] = out_ready;
                    out_last     = req_last[i] | (beat_cnt == CNT_W'(MAX_BEATS - 1));
                end
            end
            out_sel_gray = grant ^ (grant >> 1);
        end
    end

    assign transfer = (state == BUSY) && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (transfer) begin
                        if (out_last) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            if (grant == IDX_WIDTH'(NR_REQ - 1)) begin
                                ptr <= '0;
                            end else begin
                                ptr <= grant + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_rr_arbiter.sv
// Directed bench for gray_rr_arbiter with default parameters (4 requesters,
// 8-bit data, MAX_BEATS=8); expected values are hand-derived per step.
module tb_gray_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_sel_gray;

    int compared;
    int mismatched;

    gray_rr_arbiter #(
        .NR_REQ    (4),
        .IDX_WIDTH (2),
        .DATA_WIDTH(8),
        .MAX_BEATS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_sel_gray(out_sel_gray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_gray", 32'(out_sel_gray), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);

        // Single requester 2, three beats
        req_valid = 4'b0100;
        req_data  = 32'h00A0_0000;
        out_ready = 1'b1;
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("single_gray", 32'(out_sel_gray), 32'd3);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_ready", 32'(req_ready), 32'b0100);
        check("single_data1", 32'(out_data), 32'hA0);
        check("single_last1", 32'(out_last), 32'd0);
        tick();
        req_data = 32'h00A1_0000;
        #1;
        check("single_data2", 32'(out_data), 32'hA1);
        check("single_last2", 32'(out_last), 32'd0);
        tick();
        req_last = 4'b0100;
        req_data = 32'h00A2_0000;
        #1;
        check("single_last3", 32'(out_last), 32'd1);
        check("single_data3", 32'(out_data), 32'hA2);
        tick();
        check("single_idle_valid", 32'(out_valid), 32'd0);
        check("single_idle_gray", 32'(out_sel_gray), 32'd0);

        // ptr is now 3: with 0 and 3 valid, 3 must win
        req_valid = 4'b1001;
        req_last  = 4'b1111;
        #1;
        tick();
        check("ptr3_gray", 32'(out_sel_gray), 32'b10);
        check("ptr3_ready", 32'(req_ready), 32'b1000);
        tick();
        check("ptr3_idle_valid", 32'(out_valid), 32'd0);
        req_valid = 4'b0000;
        tick();

        // Fairness: ptr is 0, all valid, single-beat bursts
        begin
            logic [1:0] gray_exp [5];
            gray_exp[0] = 2'b00;
            gray_exp[1] = 2'b01;
            gray_exp[2] = 2'b11;
            gray_exp[3] = 2'b10;
            gray_exp[4] = 2'b00;
            req_valid = 4'b1111;
            req_data  = 32'h4433_2211;
            #1;
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("fair_gray%0d", k), 32'(out_sel_gray), 32'(gray_exp[k]));
                check($sformatf("fair_ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
                tick();
                check($sformatf("fair_idle%0d", k), 32'(out_valid), 32'd0);
            end
        end

        // Forced release: ptr is 1, requesters 1 and 2 valid, no last
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        #1;
        tick();
        check("force_gray", 32'(out_sel_gray), 32'b01);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("force_last_beat%0d", k), 32'(out_last), (k == 8) ? 32'd1 : 32'd0);
            tick();
        end
        check("force_idle_valid", 32'(out_valid), 32'd0);
        tick();
        check("force_next_gray", 32'(out_sel_gray), 32'b11);
        check("force_next_ready", 32'(req_ready), 32'b0100);
        req_last = 4'b0100;
        tick();
        req_last = 4'b0000;

        // Backpressure: ptr is 3, only requester 0 valid
        req_valid = 4'b0001;
        req_data  = 32'h0000_0055;
        #1;
        tick();
        check("bp_gray", 32'(out_sel_gray), 32'd0);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_data%0d", k), 32'(out_data), 32'h55);
            check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
            tick();
        end
        check("bp_beat_cnt", 32'(dut.beat_cnt), 32'd1);
        check("bp_still_busy", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        req_last  = 4'b0001;
        tick();
        req_last  = 4'b0000;

        // Reset at beat 2: ptr is 1, requester 2 granted
        req_valid = 4'b0100;
        #1;
        tick();
        check("rstmid_gray", 32'(out_sel_gray), 32'b11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0101;
        req_data  = 32'h0000_0077;
        #1;
        tick();
        check("rstmid_regrant_gray", 32'(out_sel_gray), 32'd0);
        check("rstmid_regrant_ready", 32'(req_ready), 32'b0001);

        // Grant lock on requester 0 while requester 3 is valid
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("lock_valid%0d", k), 32'(out_valid), 32'd0);
            check($sformatf("lock_gray%0d", k), 32'(out_sel_gray), 32'd0);
            check($sformatf("lock_ready%0d", k), 32'(req_ready), 32'b0001);
            tick();
        end
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        #1;
        check("lock_resume_valid", 32'(out_valid), 32'd1);
        check("lock_resume_data", 32'(out_data), 32'h77);
        tick();
        check("lock_release_idle", 32'(out_valid), 32'd0);
        req_last = 4'b0000;
        tick();
        check("after_lock_gray", 32'(out_sel_gray), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gray_rr_arbiter.md
GRAY_RR_ARBITER -- requirements
Module: gray_rr_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 4: number of requesters sharing the output mux.
REQ-002 SHALL have parameter IDX_WIDTH, default 2: grant index width, at least clog2(NR_REQ).
REQ-003 SHALL have parameter DATA_WIDTH, default 8: payload width per requester.
REQ-004 SHALL have parameter MAX_BEATS, default 8: maximum beats per grant before forced release (at least 1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, NR_REQ bits: per-requester valid; bit i belongs to requester i.
REQ-008 SHALL have port req_last, input, NR_REQ bits: per-requester end-of-burst marker.
REQ-009 SHALL have port req_data, input, NR_REQ*DATA_WIDTH bits: payload of requester i at bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-010 SHALL have port req_ready, output, NR_REQ bits: per-requester ready.
REQ-011 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits: payload of the granted requester.
REQ-014 SHALL have port out_last, output, 1 bit: last beat of the current grant.
REQ-015 SHALL have port out_sel_gray, output, IDX_WIDTH bits: Gray-coded grant index, grant ^ (grant >> 1).

Function
REQ-016 SHALL implement a two-state FSM, IDLE and BUSY, with a registered grant index, round-robin pointer ptr and beat counter beat_cnt.
REQ-017 In IDLE with any req_valid set, SHALL load grant with the first set index searched from ptr upward, wrapping at NR_REQ-1 to 0, and enter BUSY next cycle.
REQ-018 In IDLE with no req_valid set, SHALL remain in IDLE with all state held.
REQ-019 In IDLE, SHALL drive out_valid=0, req_ready=0, out_last=0, out_sel_gray=0 and out_data=0.
REQ-020 Arbitration latency SHALL be exactly 1 cycle, from the cycle req_valid is seen in IDLE to the first cycle in BUSY.
REQ-021 In BUSY, out_valid SHALL equal req_valid[grant] and out_data SHALL equal the granted payload, both combinational.
REQ-022 In BUSY, req_ready[grant] SHALL equal out_ready and all other req_ready bits SHALL be 0.
REQ-023 In BUSY, out_sel_gray SHALL equal grant ^ (grant >> 1).
REQ-024 A transfer SHALL be defined as out_valid and out_ready both high in BUSY.
REQ-025 In BUSY, out_last SHALL equal req_last[grant] OR (beat_cnt == MAX_BEATS-1).
REQ-026 On a transfer with out_last=0, beat_cnt SHALL increment by 1.
REQ-027 On a transfer with out_last=1, SHALL return to IDLE, clear beat_cnt, and set ptr to grant+1 (wrapping NR_REQ-1 to 0).
REQ-028 A forced release at MAX_BEATS SHALL behave identically to a release on req_last.
REQ-029 Grant SHALL stay locked while req_valid[grant] deasserts mid-burst; other requesters' valid SHALL be ignored.
REQ-030 Changes to req_valid of non-granted requesters SHALL have no effect on any output in BUSY.
REQ-031 With NR_REQ not a power of two, indices at or above NR_REQ SHALL never be granted.

Reset
REQ-032 When rst is high at a clock edge, SHALL set state=IDLE, grant=0, ptr=0 and beat_cnt=0; outputs then take their IDLE values.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no further transfer, and SHALL take priority over any transfer in that cycle.

Verification
REQ-034 Single requester: req_valid=4'b0100, 3-beat burst with last on beat 3, out_ready=1 -> out_sel_gray=2'b11, 3 transfers, IDLE after, ptr=3.
REQ-035 Fairness: all req_valid=1, single-beat bursts -> grant sequence 0,1,2,3,0, Gray codes 00,01,11,10,00, with an IDLE cycle between grants.
REQ-036 Forced release: MAX_BEATS=8, requester 1 never asserts last -> out_last high on beat 8, release follows, and requester 2 wins if valid.
REQ-037 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data held, beat_cnt unchanged, req_ready[grant]=0.
REQ-038 Reset mid-burst at beat 2 -> next cycle out_valid=0 and req_ready=0; the next grant searches from index 0.
REQ-039 Grant lock: requester 0 drops valid for 3 cycles mid-burst while requester 3 is valid -> grant stays 0 and out_valid=0 for those cycles.
